rf_wb_arbiter: RTL

//   Writeback front-end for the 3-port register file: arbitrates ALU and LSU results

---
 rtl/rf_wb_arbiter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Writeback front-end: round-robin arbitration of ALU/LSU results into an in-order FIFO,
// drained one entry per cycle onto the register-file write port, with forwarding lookup.
module rf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic [4:0]               p0_addr,
    input  logic [31:0]              p0_data,
    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic [4:0]               p1_addr,
    input  logic [31:0]              p1_data,
    input  logic                     stall,
    output logic                     en4w,
    output logic [4:0]               addr_w0,
    output logic [31:0]              data_i0,
    input  logic [4:0]               q_addr,
    output logic                     q_hit,
    output logic [31:0]              q_data,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             rr_reg, rr_next;
    logic             en4w_reg, en4w_next;
    logic [4:0]       addr_w0_reg, addr_w0_next;
    logic [31:0]      data_i0_reg, data_i0_next;

    logic             full;
    logic             grant0, grant1;
    logic             push, pop;
    logic [4:0]       push_addr;
    logic [31:0]      push_data;

    // Readiness comes only from registered state; a pop in this cycle does not free a slot early.
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign p0_ready = !full && (!p1_valid || !rr_reg);
    assign p1_ready = !full && (!p0_valid ||  rr_reg);

    assign grant0    = p0_valid && p0_ready;
    assign grant1    = p1_valid && p1_ready;
    assign push_addr = grant1 ? p1_addr : p0_addr;
    assign push_data = grant1 ? p1_data : p0_data;
    // Writes to x0 complete the handshake but are dropped here.
    assign push      = (grant0 || grant1) && (push_addr != 5'd0);
    assign pop       = (count_reg != '0) && !stall;

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        rr_next      = rr_reg;
        en4w_next    = 1'b0;
        addr_w0_next = addr_w0_reg;
        data_i0_next = data_i0_reg;

        if (p0_valid && p1_valid && (grant0 || grant1)) begin
            rr_next = grant0;
        end
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next  = rd_ptr_reg + 1'b1;
            en4w_next    = 1'b1;
            addr_w0_next = addr_mem[rd_ptr_reg];
            data_i0_next = data_mem[rd_ptr_reg];
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            rr_reg      <= 1'b0;
            en4w_reg    <= 1'b0;
            addr_w0_reg <= '0;
            data_i0_reg <= '0;
        end else begin
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            rr_reg      <= rr_next;
            en4w_reg    <= en4w_next;
            addr_w0_reg <= addr_w0_next;
            data_i0_reg <= data_i0_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= push_addr;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    // Slot gi is the gi-th oldest entry; a higher gi is younger.
    logic [DEPTH-1:0] slot_hit;
    logic [31:0]      slot_data [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [PTR_W-1:0] slot_idx;
        assign slot_idx      = rd_ptr_reg + PTR_W'(gi);
        assign slot_hit[gi]  = (CNT_W'(gi) < count_reg) && (addr_mem[slot_idx] == q_addr);
        assign slot_data[gi] = data_mem[slot_idx];
    end

    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_addr != 5'd0) begin
            if (en4w_reg && (addr_w0_reg == q_addr)) begin
                q_hit  = 1'b1;
                q_data = data_i0_reg;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (slot_hit[k]) begin
                    q_hit  = 1'b1;
                    q_data = slot_data[k];
                end
            end
        end
    end

    assign en4w      = en4w_reg;
    assign addr_w0   = addr_w0_reg;
    assign data_i0   = data_i0_reg;
    assign occupancy = count_reg;

endmodule
